k005297_byteemitcntr: RTL



---
 rtl/k005297_byteemitcntr.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/k005297_byteemitcntr.sv
// Byte emission counter for the K005297 bubble controller write path.
//
// Accepts bytes from the page-buffer/DMA side over a valid/ack handshake into a
// one-byte holding register. A second register (the shifter) serialises the
// current byte LSB-first onto the bubble write bit slots decoded from the
// ROT20 timing ring. Each byte boundary, and any underrun, is reported to the
// sequencer on the done-sample phases of the ring.
//
// Ports
//   i_MCLK           master clock
//   i_RST_n          synchronous active-low reset, sampled on every i_MCLK edge
//   i_CLK2M_PCEN_n   2 MHz clock enable, active-low; all other state holds when high
//   i_ROT20_n        one-cold 20-phase timing ring
//   i_4BEN_n         0: four bit slots per rotation, 1: two bit slots per rotation
//   i_ACC_ACT_n      access active, active-low; high flushes the block
//   i_NEWBYTE        start or restart of the serial stream
//   i_BYTE_VALID     source presents a byte on i_BYTE
//   i_BYTE           byte to write
//   o_BYTE_ACK       byte captured into the holding register (one enable period)
//   o_BITSLOT_WR     a bit is emitted in this slot (one enable period)
//   o_BITDATA        serial bit value, holds between emitted bits
//   o_BYTEEMIT_DONE  byte boundary reached or write wait, updated on done-sample phases
//   o_BUBWR_WAIT     underrun: shifter drained and no byte held

module k005297_byteemitcntr (
  input  logic        i_MCLK,
  input  logic        i_RST_n,
  input  logic        i_CLK2M_PCEN_n,
  input  logic [19:0] i_ROT20_n,
  input  logic        i_4BEN_n,
  input  logic        i_ACC_ACT_n,
  input  logic        i_NEWBYTE,
  input  logic        i_BYTE_VALID,
  input  logic [7:0]  i_BYTE,
  output logic        o_BYTE_ACK,
  output logic        o_BITSLOT_WR,
  output logic        o_BITDATA,
  output logic        o_BYTEEMIT_DONE,
  output logic        o_BUBWR_WAIT
);

  typedef enum logic [1:0] {
    StIdle,
    StPrime,
    StShift,
    StWait
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  hold_q, hold_d;
  logic        hold_full_q, hold_full_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bitcnt_q, bitcnt_d;
  logic        boundary_q, boundary_d;
  logic        byte_ack_q, byte_ack_d;
  logic        bitslot_wr_q, bitslot_wr_d;
  logic        bitdata_q, bitdata_d;
  logic        byteemit_done_q, byteemit_done_d;
  logic        bubwr_wait_q, bubwr_wait_d;

  logic        bit_strobe;
  logic        done_strobe;
  logic        can_capture;

  // Only phases 0/3/5/8/10/13/15/18 are decoded; the rest of the ring is unused.
  logic        unused_rot;
  assign unused_rot = ^{i_ROT20_n[19], i_ROT20_n[17:16], i_ROT20_n[14], i_ROT20_n[12:11],
                        i_ROT20_n[9], i_ROT20_n[7:6], i_ROT20_n[4], i_ROT20_n[2:1]};

  // Bit slots on phases 0/5, plus 10/15 in four-slot mode.
  assign bit_strobe = ~i_ROT20_n[0] | ~i_ROT20_n[5] |
                      (~i_4BEN_n & (~i_ROT20_n[10] | ~i_ROT20_n[15]));

  // Done samples on phases 3/8, plus 13/18 in four-slot mode.
  assign done_strobe = ~i_ROT20_n[3] | ~i_ROT20_n[8] |
                       (~i_4BEN_n & (~i_ROT20_n[13] | ~i_ROT20_n[18]));

  // Capture decision is made on the pre-edge hold state, so it never collides
  // with a shifter load, which requires the holding register to be full.
  assign can_capture = ~hold_full_q & i_BYTE_VALID;

  always_comb begin
    state_d         = state_q;
    hold_d          = hold_q;
    hold_full_d     = hold_full_q;
    shift_d         = shift_q;
    bitcnt_d        = bitcnt_q;
    boundary_d      = boundary_q;
    byte_ack_d      = 1'b0;
    bitslot_wr_d    = 1'b0;
    bitdata_d       = bitdata_q;
    byteemit_done_d = byteemit_done_q;
    bubwr_wait_d    = bubwr_wait_q;

    if (i_ACC_ACT_n) begin
      // Access dropped: flush everything back to the reset state.
      state_d         = StIdle;
      hold_d          = 8'h00;
      hold_full_d     = 1'b0;
      shift_d         = 8'h00;
      bitcnt_d        = 3'h7;
      boundary_d      = 1'b0;
      bitdata_d       = 1'b0;
      byteemit_done_d = 1'b0;
      bubwr_wait_d    = 1'b0;
    end else begin
      if (can_capture) begin
        hold_d      = i_BYTE;
        hold_full_d = 1'b1;
        byte_ack_d  = 1'b1;
      end

      // Report uses the registered wait flag; boundary is consumed by the sample.
      if (done_strobe) begin
        byteemit_done_d = boundary_q | bubwr_wait_q;
        boundary_d      = 1'b0;
      end

      unique case (state_q)
        StIdle: begin
          if (i_NEWBYTE) begin
            state_d = StPrime;
          end
        end

        StPrime: begin
          if (hold_full_q) begin
            shift_d     = hold_q;
            bitcnt_d    = 3'h7;
            hold_full_d = 1'b0;
            state_d     = StShift;
          end
        end

        StShift: begin
          if (i_NEWBYTE) begin
            // Restart wins over a coincident bit slot; the held byte survives.
            shift_d  = 8'h00;
            bitcnt_d = 3'h7;
            state_d  = StPrime;
          end else if (bit_strobe) begin
            bitdata_d    = shift_q[0];
            bitslot_wr_d = 1'b1;
            shift_d      = {1'b0, shift_q[7:1]};
            bitcnt_d     = bitcnt_q - 3'd1;
            if (bitcnt_q == 3'd0) begin
              boundary_d = 1'b1;
              bitcnt_d   = 3'h7;
              if (hold_full_q) begin
                shift_d     = hold_q;
                hold_full_d = 1'b0;
              end else begin
                state_d = StWait;
              end
            end
          end
        end

        StWait: begin
          if (i_NEWBYTE) begin
            shift_d  = 8'h00;
            bitcnt_d = 3'h7;
            state_d  = StPrime;
          end else if (hold_full_q) begin
            shift_d     = hold_q;
            bitcnt_d    = 3'h7;
            hold_full_d = 1'b0;
            state_d     = StShift;
          end
        end

        default: begin
          state_d = StIdle;
        end
      endcase

      bubwr_wait_d = (state_d == StWait);
    end
  end

  always_ff @(posedge i_MCLK) begin
    if (!i_RST_n) begin
      state_q         <= StIdle;
      hold_q          <= 8'h00;
      hold_full_q     <= 1'b0;
      shift_q         <= 8'h00;
      bitcnt_q        <= 3'h7;
      boundary_q      <= 1'b0;
      byte_ack_q      <= 1'b0;
      bitslot_wr_q    <= 1'b0;
      bitdata_q       <= 1'b0;
      byteemit_done_q <= 1'b0;
      bubwr_wait_q    <= 1'b0;
    end else if (!i_CLK2M_PCEN_n) begin
      state_q         <= state_d;
      hold_q          <= hold_d;
      hold_full_q     <= hold_full_d;
      shift_q         <= shift_d;
      bitcnt_q        <= bitcnt_d;
      boundary_q      <= boundary_d;
      byte_ack_q      <= byte_ack_d;
      bitslot_wr_q    <= bitslot_wr_d;
      bitdata_q       <= bitdata_d;
      byteemit_done_q <= byteemit_done_d;
      bubwr_wait_q    <= bubwr_wait_d;
    end
  end

  assign o_BYTE_ACK      = byte_ack_q;
  assign o_BITSLOT_WR    = bitslot_wr_q;
  assign o_BITDATA       = bitdata_q;
  assign o_BYTEEMIT_DONE = byteemit_done_q;
  assign o_BUBWR_WAIT    = bubwr_wait_q;

endmodule
